// File: rtl/lifo_stack.sv
// -----------------------------------------------------------------------------
// lifo_stack
//   Parametrised synchronous LIFO used as the call/data stack beside the
//   control unit. The top entry lives in a register (rd) so the read port has
//   no RAM latency. The RAM holds only the entries below the top. Entry k of
//   the stack (0 = bottom) is at mem[k] for k < count-1.
//
// Parameters
//   WIDTH      data word width
//   DEPTH      number of entries (>= 2)
//   ADD_WIDTH  pointer width, 2**ADD_WIDTH >= DEPTH
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   push       push enable (with pop: replace top)
//   pop        pop enable
//   clr        synchronous flush, also clears faults, beats push/pop
//   wr         write data for push / replace
//   rd         registered top-of-stack value, 0 when empty
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky, push-only attempted while full
//   underflow  sticky, pop-only attempted while empty
//   mem_fault  overflow | underflow
// -----------------------------------------------------------------------------
module lifo_stack #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned ADD_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 clr,
   input  logic [WIDTH-1:0]     wr,
   output logic [WIDTH-1:0]     rd,
   output logic [ADD_WIDTH:0]   count,
   output logic                 empty,
   output logic                 full,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 mem_fault
);

   localparam int unsigned CW = ADD_WIDTH + 1;
   localparam int unsigned AW = ADD_WIDTH;

   // Parameter sanity, caught at elaboration
   if (DEPTH < 2) begin : g_bad_depth
      $error("lifo_stack: DEPTH must be >= 2");
   end
   if ((64'(1) << ADD_WIDTH) < 64'(DEPTH)) begin : g_bad_addr
      $error("lifo_stack: 2**ADD_WIDTH must be >= DEPTH");
   end

   // Operation decode codes
   typedef enum logic [1:0] {
      OP_IDLE    = 2'b00,
      OP_POP     = 2'b01,
      OP_PUSH    = 2'b10,
      OP_REPLACE = 2'b11
   } op_e;

   // Architectural state
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rd_q, rd_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   // Storage for entries beneath the top
   logic [WIDTH-1:0] mem [DEPTH];

   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;
   logic [AW-1:0]    mem_raddr;
   logic [WIDTH-1:0] mem_rdata;

   logic             empty_c;
   logic             full_c;
   op_e              op;

   assign empty_c = (count_q == '0);
   assign full_c  = (count_q == CW'(DEPTH));
   assign op      = op_e'({push, pop});

   // Entry that becomes the new top after a pop (index count-2)
   assign mem_raddr = AW'(count_q - CW'(2));
   assign mem_rdata = mem[mem_raddr];

   // Next-state decode, clr has priority over any operation
   always_comb begin
      count_d     = count_q;
      rd_d        = rd_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      mem_we      = 1'b0;
      mem_waddr   = AW'(count_q - CW'(1));
      mem_wdata   = rd_q;

      if (clr) begin
         count_d     = '0;
         rd_d        = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         unique case (op)
            OP_IDLE: begin
            end
            OP_PUSH: begin
               if (full_c) begin
                  overflow_d = 1'b1;
               end else begin
                  // Old top sinks into the RAM; nothing to save when empty
                  mem_we  = !empty_c;
                  rd_d    = wr;
                  count_d = count_q + CW'(1);
               end
            end
            OP_POP: begin
               if (empty_c) begin
                  underflow_d = 1'b1;
               end else begin
                  count_d = count_q - CW'(1);
                  rd_d    = (count_q == CW'(1)) ? '0 : mem_rdata;
               end
            end
            OP_REPLACE: begin
               // Overwrite top in place; on an empty stack this is a push
               rd_d = wr;
               if (empty_c) begin
                  count_d = CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         rd_q        <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         rd_q        <= rd_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // RAM write port, contents not reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign rd        = rd_q;
   assign count     = count_q;
   assign empty     = empty_c;
   assign full      = full_c;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign mem_fault = overflow_q | underflow_q;

endmodule

// File: tb/tb_lifo_stack.sv
// -----------------------------------------------------------------------------
// tb_lifo_stack
//   Directed scenarios plus a long random push/pop/replace/clr run against a
//   queue model, for a 4-deep, 16-bit stack.
// -----------------------------------------------------------------------------
module tb_lifo_stack;

   localparam int unsigned WIDTH     = 16;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned ADD_WIDTH = 2;

   logic                 clk;
   logic                 rst;
   logic                 push;
   logic                 pop;
   logic                 clr;
   logic [WIDTH-1:0]     wr;
   logic [WIDTH-1:0]     rd;
   logic [ADD_WIDTH:0]   count;
   logic                 empty;
   logic                 full;
   logic                 overflow;
   logic                 underflow;
   logic                 mem_fault;

   int checks = 0;
   int errors = 0;

   lifo_stack #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .ADD_WIDTH (ADD_WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .clr       (clr),
      .wr        (wr),
      .rd        (rd),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow),
      .mem_fault (mem_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge
   task automatic cyc(input logic p, input logic po, input logic c, input logic [WIDTH-1:0] w);
      push = p;
      pop  = po;
      clr  = c;
      wr   = w;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
      clr  = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (count !== 3'd0 || rd !== 16'h0 || empty !== 1'b1 || full !== 1'b0 || mem_fault !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: count=%0d rd=%h empty=%b full=%b fault=%b, want 0 0000 1 0 0",
                  count, rd, empty, full, mem_fault);
      end
      cyc(1, 0, 0, 16'h0001);
      cyc(1, 0, 0, 16'h0002);
      cyc(1, 0, 0, 16'h0003);
      checks++;
      if (count !== 3'd3 || rd !== 16'h0003) begin
         errors++;
         $display("FAIL reset_prefill: count=%0d rd=%h, want 3 0003", count, rd);
      end
      // Asynchronous reset asserted mid-cycle
      rst = 1'b1;
      #1;
      checks++;
      if (count !== 3'd0 || rd !== 16'h0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: count=%0d rd=%h empty=%b ovf=%b unf=%b, want 0 0000 1 0 0",
                  count, rd, empty, overflow, underflow);
      end
      #2;
      rst = 1'b0;
      cyc(0, 1, 0, 16'h0);
      checks++;
      if (underflow !== 1'b1 || mem_fault !== 1'b1 || count !== 3'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_underflow: unf=%b fault=%b count=%0d ovf=%b, want 1 1 0 0",
                  underflow, mem_fault, count, overflow);
      end
      cyc(0, 0, 1, 16'h0);
   endtask

   task automatic test_lifo_order;
      cyc(1, 0, 0, 16'h1111);
      cyc(1, 0, 0, 16'h2222);
      cyc(1, 0, 0, 16'h3333);
      checks++;
      if (rd !== 16'h3333 || count !== 3'd3) begin
         errors++;
         $display("FAIL lifo_push3: rd=%h count=%0d, want 3333 3", rd, count);
      end
      cyc(0, 1, 0, 16'h0);
      checks++;
      if (rd !== 16'h2222 || count !== 3'd2) begin
         errors++;
         $display("FAIL lifo_pop1: rd=%h count=%0d, want 2222 2", rd, count);
      end
      cyc(0, 1, 0, 16'h0);
      checks++;
      if (rd !== 16'h1111 || count !== 3'd1) begin
         errors++;
         $display("FAIL lifo_pop2: rd=%h count=%0d, want 1111 1", rd, count);
      end
      cyc(0, 1, 0, 16'h0);
      checks++;
      if (rd !== 16'h0000 || count !== 3'd0 || empty !== 1'b1 || mem_fault !== 1'b0) begin
         errors++;
         $display("FAIL lifo_pop3: rd=%h count=%0d empty=%b fault=%b, want 0000 0 1 0",
                  rd, count, empty, mem_fault);
      end
   endtask

   task automatic test_full_overflow;
      cyc(1, 0, 0, 16'h00A0);
      cyc(1, 0, 0, 16'h00A1);
      cyc(1, 0, 0, 16'h00A2);
      cyc(1, 0, 0, 16'h00A3);
      checks++;
      if (full !== 1'b1 || count !== 3'd4 || rd !== 16'h00A3 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_fill: full=%b count=%0d rd=%h ovf=%b, want 1 4 00a3 0", full, count, rd, overflow);
      end
      cyc(1, 0, 0, 16'h00FF);
      checks++;
      if (count !== 3'd4 || rd !== 16'h00A3 || overflow !== 1'b1 || mem_fault !== 1'b1) begin
         errors++;
         $display("FAIL full_overflow: count=%0d rd=%h ovf=%b fault=%b, want 4 00a3 1 1", count, rd, overflow, mem_fault);
      end
      cyc(0, 1, 0, 16'h0);
      checks++;
      if (rd !== 16'h00A2 || count !== 3'd3 || full !== 1'b0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL full_pop: rd=%h count=%0d full=%b ovf=%b, want 00a2 3 0 1", rd, count, full, overflow);
      end
      cyc(0, 1, 0, 16'h0);
      cyc(0, 1, 0, 16'h0);
      checks++;
      if (rd !== 16'h00A0 || count !== 3'd1) begin
         errors++;
         $display("FAIL full_drain: rd=%h count=%0d, want 00a0 1", rd, count);
      end
      cyc(0, 0, 1, 16'h0);
   endtask

   task automatic test_replace;
      cyc(1, 0, 0, 16'h0010);
      cyc(1, 0, 0, 16'h0020);
      cyc(1, 1, 0, 16'h0099);
      checks++;
      if (count !== 3'd2 || rd !== 16'h0099 || mem_fault !== 1'b0) begin
         errors++;
         $display("FAIL replace_top: count=%0d rd=%h fault=%b, want 2 0099 0", count, rd, mem_fault);
      end
      cyc(0, 1, 0, 16'h0);
      checks++;
      if (rd !== 16'h0010 || count !== 3'd1) begin
         errors++;
         $display("FAIL replace_pop: rd=%h count=%0d, want 0010 1", rd, count);
      end
      cyc(0, 1, 0, 16'h0);
      cyc(1, 1, 0, 16'h0055);
      checks++;
      if (count !== 3'd1 || rd !== 16'h0055 || mem_fault !== 1'b0 || empty !== 1'b0) begin
         errors++;
         $display("FAIL replace_empty: count=%0d rd=%h fault=%b empty=%b, want 1 0055 0 0",
                  count, rd, mem_fault, empty);
      end
      // Replace while full keeps count at DEPTH with no overflow
      cyc(1, 0, 0, 16'h0056);
      cyc(1, 0, 0, 16'h0057);
      cyc(1, 0, 0, 16'h0058);
      cyc(1, 1, 0, 16'h0077);
      checks++;
      if (count !== 3'd4 || rd !== 16'h0077 || overflow !== 1'b0 || full !== 1'b1) begin
         errors++;
         $display("FAIL replace_full: count=%0d rd=%h ovf=%b full=%b, want 4 0077 0 1", count, rd, overflow, full);
      end
      cyc(0, 1, 0, 16'h0);
      checks++;
      if (rd !== 16'h0057 || count !== 3'd3) begin
         errors++;
         $display("FAIL replace_full_pop: rd=%h count=%0d, want 0057 3", rd, count);
      end
      cyc(0, 0, 1, 16'h0);
   endtask

   task automatic test_flush;
      cyc(0, 1, 0, 16'h0);
      cyc(1, 0, 0, 16'h0001);
      cyc(1, 0, 0, 16'h0002);
      cyc(1, 0, 0, 16'h0003);
      checks++;
      if (count !== 3'd3 || underflow !== 1'b1 || rd !== 16'h0003) begin
         errors++;
         $display("FAIL flush_setup: count=%0d unf=%b rd=%h, want 3 1 0003", count, underflow, rd);
      end
      cyc(1, 0, 1, 16'h0009);
      checks++;
      if (count !== 3'd0 || rd !== 16'h0 || underflow !== 1'b0 || mem_fault !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL flush_clr: count=%0d rd=%h unf=%b fault=%b empty=%b, want 0 0000 0 0 1",
                  count, rd, underflow, mem_fault, empty);
      end
      cyc(1, 0, 0, 16'h0007);
      checks++;
      if (count !== 3'd1 || rd !== 16'h0007) begin
         errors++;
         $display("FAIL flush_push: count=%0d rd=%h, want 1 0007", count, rd);
      end
      cyc(0, 0, 1, 16'h0);
   endtask

   task automatic test_back_to_back;
      logic [WIDTH-1:0] model[$];
      logic             m_ovf;
      logic             m_unf;
      logic             p, po, c;
      logic [WIDTH-1:0] w;
      logic [WIDTH-1:0] e_rd;
      logic [2:0]       e_cnt;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         c  = ($urandom_range(0, 63) == 0);
         p  = 1'($urandom_range(0, 1));
         po = 1'($urandom_range(0, 1));
         w  = WIDTH'($urandom);
         if (c) begin
            model.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end else if (p && po) begin
            if (model.size() == 0) model.push_back(w);
            else model[model.size()-1] = w;
         end else if (p) begin
            if (model.size() == DEPTH) m_ovf = 1'b1;
            else model.push_back(w);
         end else if (po) begin
            if (model.size() == 0) m_unf = 1'b1;
            else void'(model.pop_back());
         end
         e_cnt = 3'(model.size());
         e_rd  = (model.size() == 0) ? '0 : model[model.size()-1];
         cyc(p, po, c, w);
         checks++;
         if (rd !== e_rd || count !== e_cnt) begin
            errors++;
            $display("FAIL b2b_data[%0d]: rd=%h count=%0d, want %h %0d", i, rd, count, e_rd, e_cnt);
         end
         checks++;
         if (empty !== (e_cnt == 0) || full !== (e_cnt == 3'(DEPTH))) begin
            errors++;
            $display("FAIL b2b_status[%0d]: empty=%b full=%b, want %b %b",
                     i, empty, full, (e_cnt == 0), (e_cnt == 3'(DEPTH)));
         end
         checks++;
         if (overflow !== m_ovf || underflow !== m_unf || mem_fault !== (m_ovf | m_unf)) begin
            errors++;
            $display("FAIL b2b_fault[%0d]: ovf=%b unf=%b fault=%b, want %b %b %b",
                     i, overflow, underflow, mem_fault, m_ovf, m_unf, m_ovf | m_unf);
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      push = 1'b0;
      pop  = 1'b0;
      clr  = 1'b0;
      wr   = '0;
      test_reset();
      test_lifo_order();
      test_full_overflow();
      test_replace();
      test_flush();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
Parametrised synchronous LIFO stack, the next generation of the Neptune I stack register. Adds full/empty/count status, a registered top-of-stack read port, a simultaneous push+pop "replace top" operation, a synchronous flush, and separate sticky overflow/underflow faults. Sits beside the control unit as the call/data stack and drives its fault line into the processor's exception logic.

Parameters:
WIDTH, 16, data word width in bits
DEPTH, 256, number of entries (>=2)
ADD_WIDTH, 8, pointer width; 2**ADD_WIDTH >= DEPTH required (elaboration error otherwise)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
push  input  1  push enable
pop  input  1  pop enable
clr  input  1  synchronous flush (empties stack, clears faults)
wr  input  WIDTH  write data for push / replace
rd  output  WIDTH  registered top-of-stack value
count  output  ADD_WIDTH+1  number of valid entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: push attempted while full (push-only)
underflow  output  1  sticky: pop attempted while empty (pop-only)
mem_fault  output  1  overflow | underflow

Behaviour:
- Reset (rst=1, asynchronous, any time incl. mid-operation): count=0, rd=0, overflow=0, underflow=0; empty=1, full=0, mem_fault=0. Memory contents not reset, not observable.
- empty, full, mem_fault combinational from registered count/flags; no extra latency.
- rd always equals current top entry, 0 when empty. Updated on the same edge as the operation: value visible the cycle after push/pop is sampled (1-cycle latency). No read-during-write hazard visible at rd.
- Priority per edge: clr > operation decode. clr=1: count=0, rd=0, both fault flags cleared; push/pop ignored that cycle.
- Operation decode (clr=0):
  - idle (push=0, pop=0): no change.
  - push only, not full: entry stored, count+1, rd=wr.
  - push only, full: ignored (no data change, count stays DEPTH), overflow<=1.
  - pop only, not empty: count-1, rd=new top entry (0 if count becomes 0).
  - pop only, empty: ignored, underflow<=1.
  - push+pop, not empty (incl. full): replace top, rd=wr, count unchanged, no fault.
  - push+pop, empty: treated as push, count=1, rd=wr, no fault.
- Fault flags sticky until rst or clr; a fault does not block later valid operations.
- count never wraps: saturates by rule above at 0 and DEPTH.
- Storage: DEPTH x WIDTH array inferable as RAM plus top-of-stack register; single write per cycle.

Test Plan:
- Reset/idle: assert rst mid-cycle after 3 pushes -> immediately count=0, rd=0, empty=1, faults 0; after release, pop -> underflow=1, mem_fault=1, count=0.
- LIFO order (WIDTH=16, DEPTH=4): push 0x1111,0x2222,0x3333 -> rd=0x3333, count=3; pop x3 -> rd 0x2222, 0x1111, 0x0000, empty=1, no faults.
- Full/overflow (DEPTH=4): push 0xA0..0xA3 -> full=1, count=4, rd=0xA3; push 0xFF -> count=4, rd=0xA3, overflow=1; pop -> rd=0xA2 (0xFF never stored).
- Replace top: stack [0x10,0x20]; push+pop wr=0x99 -> count=2, rd=0x99; pop -> rd=0x10. On empty stack push+pop wr=0x55 -> count=1, rd=0x55, no fault.
- Flush: stack count=3 with underflow=1 set earlier; clr=1 with push=1 same cycle -> count=0, rd=0, underflow=0, mem_fault=0; subsequent push 0x7 -> count=1, rd=0x7.
- Back-to-back random push/pop/replace for 10k cycles vs. reference model queue -> rd, count, empty, full, faults match every cycle.
